// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its counters.
package fetch_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] PROG_I2F = 2'b00;
  localparam logic [1:0] PROG_F2I = 2'b01;
  localparam logic [1:0] PROG_FAD = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller: Start/Done handshake, jump/branch/sequential flow,
// stall support, saturating performance counters and a sticky end-of-ROM fault.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned IW   = 16,
  parameter int unsigned OFFW = 8,
  parameter int unsigned CW   = 32
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic            Stall,
  input  logic            JumpEn,
  input  logic [IW-1:0]   JumpTarget,
  input  logic            BranchEn,
  input  logic [OFFW-1:0] BranchOffset,
  input  logic            HaltReq,
  output logic [IW-1:0]   InstAddress,
  output logic [1:0]      ProgMux,
  output logic            FetchValid,
  output logic            Busy,
  output logic            Done,
  output logic [CW-1:0]   CycleCount,
  output logic [CW-1:0]   InstCount,
  output logic            Fault
);

  state_e        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [1:0]    prog_q, prog_d;
  logic          fault_q, fault_d;

  logic          running;
  logic          start_accept;
  logic          advance;
  logic          pc_at_end;
  logic [IW-1:0] branch_ext;

  assign running      = (state_q == StRun);
  assign start_accept = !running && Start;
  // Halt still consumes its cycle as an instruction; only a plain stall does not.
  assign advance      = running && !HaltReq && !Stall;
  assign pc_at_end    = (pc_q == '1);
  assign branch_ext   = IW'($signed(BranchOffset));

  // State register
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) state_d = StRun;
      end
      StRun: begin
        if (HaltReq) begin
          state_d = StDone;
        end else if (!Stall && !JumpEn && !BranchEn && pc_at_end) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    Busy       = 1'b0;
    FetchValid = 1'b0;
    Done       = 1'b0;
    unique case (state_q)
      StRun: begin
        Busy       = 1'b1;
        FetchValid = 1'b1;
      end
      StDone:  Done = 1'b1;
      default: ;
    endcase
  end

  // PC, program select and fault datapath
  always_comb begin
    pc_d    = pc_q;
    prog_d  = prog_q;
    fault_d = fault_q;
    if (start_accept) begin
      pc_d    = '0;
      prog_d  = ProgSel;
      fault_d = 1'b0;
    end else if (advance) begin
      if (JumpEn) begin
        pc_d = JumpTarget;
      end else if (BranchEn) begin
        pc_d = pc_q + branch_ext;
      end else begin
        pc_d = pc_q + IW'(1);
        if (pc_at_end) fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      pc_q    <= '0;
      prog_q  <= PROG_I2F;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      prog_q  <= prog_d;
      fault_q <= fault_d;
    end
  end

  assign InstAddress = pc_q;
  assign ProgMux     = prog_q;
  assign Fault       = fault_q;

  sat_counter #(
    .Width (CW)
  ) u_cycle_count (
    .clk_i    (Clk),
    .rst_ni   (ResetN),
    .clear_i  (start_accept),
    .enable_i (running),
    .count_o  (CycleCount)
  );

  sat_counter #(
    .Width (CW)
  ) u_inst_count (
    .clk_i    (Clk),
    .rst_ni   (ResetN),
    .clear_i  (start_accept),
    .enable_i (running && (HaltReq || !Stall)),
    .count_o  (InstCount)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; narrow counters expose saturation.
module tb_fetch_sequencer;

  localparam int unsigned IW   = 16;
  localparam int unsigned OFFW = 8;
  localparam int unsigned CW   = 8;

  logic            Clk = 1'b0;
  logic            ResetN;
  logic            Start;
  logic [1:0]      ProgSel;
  logic            Stall;
  logic            JumpEn;
  logic [IW-1:0]   JumpTarget;
  logic            BranchEn;
  logic [OFFW-1:0] BranchOffset;
  logic            HaltReq;
  logic [IW-1:0]   InstAddress;
  logic [1:0]      ProgMux;
  logic            FetchValid;
  logic            Busy;
  logic            Done;
  logic [CW-1:0]   CycleCount;
  logic [CW-1:0]   InstCount;
  logic            Fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(
    .IW   (IW),
    .OFFW (OFFW),
    .CW   (CW)
  ) dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .Start        (Start),
    .ProgSel      (ProgSel),
    .Stall        (Stall),
    .JumpEn       (JumpEn),
    .JumpTarget   (JumpTarget),
    .BranchEn     (BranchEn),
    .BranchOffset (BranchOffset),
    .HaltReq      (HaltReq),
    .InstAddress  (InstAddress),
    .ProgMux      (ProgMux),
    .FetchValid   (FetchValid),
    .Busy         (Busy),
    .Done         (Done),
    .CycleCount   (CycleCount),
    .InstCount    (InstCount),
    .Fault        (Fault)
  );

  always #5 Clk = ~Clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_run(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, 32'(InstAddress), pc);
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    chk({tag, "_fv"}, 32'(FetchValid), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, 32'(InstAddress), 32'd0);
    chk({tag, "_prog"}, 32'(ProgMux), 32'd0);
    chk({tag, "_fv"}, 32'(FetchValid), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_cyc"}, 32'(CycleCount), 32'd0);
    chk({tag, "_inst"}, 32'(InstCount), 32'd0);
    chk({tag, "_fault"}, 32'(Fault), 32'd0);
  endtask

  task automatic do_start(input logic [1:0] sel);
    Start   = 1'b1;
    ProgSel = sel;
    step();
    Start   = 1'b0;
  endtask

  task automatic do_jump(input logic [IW-1:0] tgt);
    JumpEn     = 1'b1;
    JumpTarget = tgt;
    step();
    JumpEn     = 1'b0;
  endtask

  task automatic do_branch(input logic [OFFW-1:0] off);
    BranchEn     = 1'b1;
    BranchOffset = off;
    step();
    BranchEn     = 1'b0;
  endtask

  initial begin
    ResetN = 1'b0; Start = 1'b0; ProgSel = 2'b00; Stall = 1'b0;
    JumpEn = 1'b0; JumpTarget = '0; BranchEn = 1'b0; BranchOffset = '0; HaltReq = 1'b0;
    #1;
    step();
    step();
    chk_reset("reset");
    ResetN = 1'b1;
    step();
    chk("idle_stays", 32'(Busy), 32'd0);

    // Sequential run 0..5, then halt
    do_start(2'b01);
    chk("seq_prog", 32'(ProgMux), 32'd1);
    chk_run("seq0", 32'd0);
    chk("seq0_done", 32'(Done), 32'd0);
    step(); chk("seq1_pc", 32'(InstAddress), 32'd1);
    step(); chk("seq2_pc", 32'(InstAddress), 32'd2);
    step(); chk("seq3_pc", 32'(InstAddress), 32'd3);
    step(); step();
    chk("seq5_pc", 32'(InstAddress), 32'd5);
    HaltReq = 1'b1;
    step();
    HaltReq = 1'b0;
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_busy", 32'(Busy), 32'd0);
    chk("halt_fv", 32'(FetchValid), 32'd0);
    chk("halt_pc", 32'(InstAddress), 32'd5);
    chk("halt_inst", 32'(InstCount), 32'd6);
    chk("halt_cyc", 32'(CycleCount), 32'd6);
    step();
    chk("done_frozen_pc", 32'(InstAddress), 32'd5);
    chk("done_frozen_cyc", 32'(CycleCount), 32'd6);
    chk("done_held", 32'(Done), 32'd1);

    // Branches and jump priority
    do_start(2'b10);
    chk("br_start_done", 32'(Done), 32'd0);
    chk("br_start_cyc", 32'(CycleCount), 32'd0);
    do_jump(16'd10);
    chk_run("jmp10a", 32'd10);
    do_branch(8'hFC);
    chk_run("br_neg", 32'd6);
    do_jump(16'd10);
    do_branch(8'h7F);
    chk_run("br_pos", 32'd137);
    do_jump(16'd10);
    JumpEn = 1'b1; JumpTarget = 16'h0200; BranchEn = 1'b1; BranchOffset = 8'h05;
    step();
    JumpEn = 1'b0; BranchEn = 1'b0;
    chk_run("jmp_wins", 32'h0200);
    do_start(2'b11);
    chk("start_ignored_pc", 32'(InstAddress), 32'h0201);
    chk("start_ignored_prog", 32'(ProgMux), 32'd2);
    chk("br_run_inst", 32'(InstCount), 32'd7);
    chk("br_run_cyc", 32'(CycleCount), 32'd7);

    // Stall at PC=4
    do_jump(16'd4);
    Stall = 1'b1;
    step(); chk("stall1_pc", 32'(InstAddress), 32'd4);
    step(); step();
    chk("stall3_pc", 32'(InstAddress), 32'd4);
    chk("stall3_cyc", 32'(CycleCount), 32'd11);
    chk("stall3_inst", 32'(InstCount), 32'd8);
    Stall = 1'b0;
    step();
    chk_run("unstall", 32'd5);
    chk("unstall_cyc", 32'(CycleCount), 32'd12);
    chk("unstall_inst", 32'(InstCount), 32'd9);
    HaltReq = 1'b1; Stall = 1'b1;
    step();
    HaltReq = 1'b0; Stall = 1'b0;
    chk("halt_stall_done", 32'(Done), 32'd1);
    chk("halt_stall_pc", 32'(InstAddress), 32'd5);
    chk("halt_stall_inst", 32'(InstCount), 32'd10);
    chk("halt_stall_cyc", 32'(CycleCount), 32'd13);

    // Branch wrap is legal; sequential overflow faults
    do_start(2'b00);
    do_branch(8'hFC);
    chk_run("br_wrap", 32'hFFFC);
    chk("br_wrap_fault", 32'(Fault), 32'd0);
    do_jump(16'hFFFE);
    step();
    chk_run("seq_ffff", 32'hFFFF);
    step();
    chk("ovf_fault", 32'(Fault), 32'd1);
    chk("ovf_done", 32'(Done), 32'd1);
    chk("ovf_busy", 32'(Busy), 32'd0);
    chk("ovf_pc", 32'(InstAddress), 32'd0);
    step();
    chk("ovf_sticky", 32'(Fault), 32'd1);
    do_start(2'b00);
    chk("restart_fault", 32'(Fault), 32'd0);
    chk_run("restart", 32'd0);

    // Reset mid-run
    do_jump(16'h0033);
    chk("pre_rst_pc", 32'(InstAddress), 32'h33);
    ResetN = 1'b0;
    step();
    ResetN = 1'b1;
    chk_reset("midrun_rst");

    // Counter saturation (8-bit counters)
    do_start(2'b01);
    for (int i = 0; i < 300; i++) step();
    chk_run("sat", 32'd300);
    chk("sat_cyc", 32'(CycleCount), 32'd255);
    chk("sat_inst", 32'(InstCount), 32'd255);
    Stall = 1'b1;
    step();
    Stall = 1'b0;
    chk("sat_hold_cyc", 32'(CycleCount), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter controller for the 9-bit-instruction core; drives the instruction ROM address and program-select inputs.
- Sequences fetch from a Start pulse through sequential, jump and branch flow to a Halt, with a Start/Done handshake to the testbench or top level.
- Provides stall support, cycle and instruction counters, and a sticky fault for running off the end of ROM.

Parameters:
IW, 16, instruction address width (ROM depth 2**IW)
OFFW, 8, signed relative-branch offset width (OFFW <= IW)
CW, 32, width of performance counters

Ports:
Clk  in  1  clock, all state on rising edge
ResetN  in  1  synchronous active-low reset
Start  in  1  begin program; honoured only in IDLE or DONE
ProgSel  in  2  program to run; latched on accepted Start
Stall  in  1  hold PC this cycle (datapath busy)
JumpEn  in  1  absolute jump request
JumpTarget  in  IW  absolute target address
BranchEn  in  1  taken relative branch
BranchOffset  in  OFFW  signed two's-complement offset, relative to current PC
HaltReq  in  1  current instruction is halt
InstAddress  out  IW  PC, to ROM address
ProgMux  out  2  latched program select, to ROM
FetchValid  out  1  InstAddress is a live fetch (high only in RUN)
Busy  out  1  high in RUN
Done  out  1  high in DONE, held until next accepted Start
CycleCount  out  CW  RUN cycles since Start, saturating
InstCount  out  CW  non-stalled RUN cycles since Start, saturating
Fault  out  1  sticky: sequential PC overflow ended the run

Behaviour:
- One clock, Clk. ResetN is synchronous and active-low: sampled low at a rising edge, it forces reset state on that edge, overriding all other inputs, including mid-RUN.
- Reset values: state=IDLE, InstAddress=0, ProgMux=0, FetchValid=0, Busy=0, Done=0, CycleCount=0, InstCount=0, Fault=0.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state.
- IDLE/DONE with Start=1:
  - Next edge: state=RUN, PC=0, ProgMux=ProgSel, both counters=0, Done=0, Fault=0.
  - First fetch address 0 is visible with FetchValid=1 one cycle after Start is sampled.
- RUN:
  - Start is ignored.
  - ProgMux is stable for the whole run.
  - Per edge, priority is HaltReq > Stall > JumpEn > BranchEn > sequential:
    - HaltReq: state=DONE, PC held, Done=1 from the next cycle. InstCount and CycleCount count this cycle.
    - Stall (no halt): PC held, CycleCount+1, InstCount unchanged.
    - JumpEn: PC=JumpTarget.
    - BranchEn: PC=(PC + sign-extend(BranchOffset)) mod 2**IW. Wrap is legal, no fault.
    - Otherwise: PC=PC+1. If PC==2**IW-1: PC wraps to 0, Fault=1, state=DONE.
  - JumpEn and BranchEn together: jump wins.
  - Halt and Stall together: halt wins.
  - Non-halt, non-stall cycles increment both counters.
- DONE: PC, counters and Fault frozen; FetchValid=0, Busy=0.
- Counters saturate at 2**CW-1 and never wrap.
- Latency: control inputs sampled at edge N take effect on InstAddress after edge N. Zero combinational paths from inputs to outputs.

Decomposition:
- Shared package fetch_pkg:
  - state enum (IDLE, RUN, DONE)
  - addr_t typedef (logic [IW-1:0])
  - constant PROG_I2F=2'b00, PROG_F2I=2'b01, PROG_FAD=2'b10
- One sub-module: sat_counter (width param; clear, enable; saturates at all-ones), instanced for CycleCount and InstCount.

Test Plan:
- Reset, then Start=1 with ProgSel=2'b01 for 1 cycle; no other inputs -> next cycle ProgMux=01, InstAddress=0, FetchValid=1, Busy=1; then 1,2,3 on successive edges. HaltReq at PC=5 -> Done=1, InstAddress=5, InstCount=6, CycleCount=6.
- Branches and jump at PC=10:
  - BranchOffset=8'hFC -> PC=6.
  - BranchOffset=8'h7F -> PC=137.
  - JumpEn+BranchEn same cycle, JumpTarget=16'h0200 -> PC=0x0200.
- Stall for 3 cycles at PC=4 -> PC stays 4; CycleCount+3, InstCount+0; PC=5 after Stall drops.
- JumpTarget=16'hFFFE, then sequential flow -> PC=FFFF, then DONE with Fault=1, InstAddress=0. Start -> Fault clears, PC=0.
- ResetN=0 for one edge while in RUN at PC=0x33 -> all outputs at reset values next cycle. Start issued during RUN is ignored (PC continues, ProgMux unchanged).
